// File: rtl/rf_exec_seq_if.sv
// Bundle between the instruction sequencer and its two neighbours: the decode-side
// instruction handshake and the RegisterFile read/write ports, plus retire status.
interface rf_exec_seq_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic [ADDR_W-1:0] instr_dst;
    logic [ADDR_W-1:0] instr_src1;
    logic [ADDR_W-1:0] instr_src2;
    logic [DATA_W-1:0] instr_imm;

    logic              wr_en;
    logic [ADDR_W-1:0] dst_id;
    logic [DATA_W-1:0] dst_in;
    logic [ADDR_W-1:0] src1_id;
    logic [ADDR_W-1:0] src2_id;
    logic [DATA_W-1:0] src1_out;
    logic [DATA_W-1:0] src2_out;

    logic              done;
    logic              flag_z;
    logic              flag_c;

    // The sequencer side: takes instructions, reads and writes the RegisterFile.
    modport master (
        input  instr_valid, instr_op, instr_dst, instr_src1, instr_src2, instr_imm,
        input  src1_out, src2_out,
        output instr_ready, wr_en, dst_id, dst_in, src1_id, src2_id,
        output done, flag_z, flag_c
    );

    modport slave (
        output instr_valid, instr_op, instr_dst, instr_src1, instr_src2, instr_imm,
        output src1_out, src2_out,
        input  instr_ready, wr_en, dst_id, dst_in, src1_id, src2_id,
        input  done, flag_z, flag_c
    );
endinterface

// File: rtl/rf_exec_seq.sv
// Three-state (IDLE -> READ -> WB) executor for one register/immediate instruction at a
// time; reads operands from the RegisterFile, writes the 8-bit result back, keeps z/c flags.
module rf_exec_seq #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    rf_exec_seq_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WB} state_e;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
        OP_OR  = 3'd4, OP_XOR = 3'd5, OP_MOV = 3'd6, OP_LDI = 3'd7
    } op_e;

    state_e            r_state;
    op_e               r_op;
    logic [ADDR_W-1:0] r_dst;
    logic [DATA_W-1:0] r_imm;
    logic              r_carry;
    logic [ADDR_W-1:0] r_src1_id;
    logic [ADDR_W-1:0] r_src2_id;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_dst_id;
    logic [DATA_W-1:0] r_dst_in;
    logic              r_done;
    logic              r_flag_z;
    logic              r_flag_c;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_result;
    logic              w_carry;

    // The extra top bit of the difference is the borrow, i.e. set exactly when A < B.
    assign w_sum  = {1'b0, bus.src1_out} + {1'b0, bus.src2_out};
    assign w_diff = {1'b0, bus.src1_out} - {1'b0, bus.src2_out};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_result = '0;
        w_carry  = 1'b0;
        case (r_op)
            OP_ADD: {w_carry, w_result} = w_sum;
            OP_SUB: {w_carry, w_result} = w_diff;
            OP_AND: w_result = bus.src1_out & bus.src2_out;
            OP_OR:  w_result = bus.src1_out | bus.src2_out;
            OP_XOR: w_result = bus.src1_out ^ bus.src2_out;
            OP_MOV: w_result = bus.src1_out;
            OP_LDI: w_result = r_imm;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= OP_NOP;
            r_dst     <= '0;
            r_imm     <= '0;
            r_carry   <= 1'b0;
            r_src1_id <= '0;
            r_src2_id <= '0;
            r_wr_en   <= 1'b0;
            r_dst_id  <= '0;
            r_dst_in  <= '0;
            r_done    <= 1'b0;
            r_flag_z  <= 1'b0;
            r_flag_c  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wr_en <= 1'b0;
                    r_done  <= 1'b0;
                    if (bus.instr_valid) begin
                        r_op      <= op_e'(bus.instr_op);
                        r_dst     <= bus.instr_dst;
                        r_imm     <= bus.instr_imm;
                        r_src1_id <= bus.instr_src1;
                        r_src2_id <= bus.instr_src2;
                        r_state   <= S_READ;
                    end
                end
                S_READ: begin
                    r_carry  <= w_carry;
                    r_dst_id <= r_dst;
                    r_dst_in <= w_result;
                    r_wr_en  <= (r_op != OP_NOP);
                    r_done   <= 1'b1;
                    r_state  <= S_WB;
                end
                S_WB: begin
                    r_wr_en <= 1'b0;
                    r_done  <= 1'b0;
                    // Flags commit together with the RegisterFile write; NOP leaves them alone.
                    if (r_op == OP_ADD || r_op == OP_SUB) begin
                        r_flag_z <= (r_dst_in == '0);
                        r_flag_c <= r_carry;
                    end else if (r_op != OP_NOP) begin
                        r_flag_z <= (r_dst_in == '0);
                        r_flag_c <= 1'b0;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_ready = (r_state == S_IDLE);
    assign bus.src1_id     = r_src1_id;
    assign bus.src2_id     = r_src2_id;
    assign bus.wr_en       = r_wr_en;
    assign bus.dst_id      = r_dst_id;
    assign bus.dst_in      = r_dst_in;
    assign bus.done        = r_done;
    assign bus.flag_z      = r_flag_z;
    assign bus.flag_c      = r_flag_c;
endmodule

// File: tb/tb_rf_exec_seq.sv
// Bench for rf_exec_seq: behavioural RegisterFile, write scoreboard, table of instructions
// with hand-derived results, plus held-valid and reset-abort sequences.
module tb_rf_exec_seq;
    localparam logic [2:0] OP_NOP = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
                           OP_OR  = 3'd4, OP_XOR = 3'd5, OP_MOV = 3'd6, OP_LDI = 3'd7;

    typedef struct {
        logic [2:0] op;
        logic [3:0] dst;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [7:0] imm;
        logic [7:0] res;
        logic       z;
        logic       c;
    } vec_t;

    typedef struct {
        logic [3:0] dst;
        logic [7:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    rf_exec_seq_if bus ();

    rf_exec_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] rf [16] = '{default: 8'h00};
    assign bus.src1_out = rf[bus.src1_id];
    assign bus.src2_out = rf[bus.src2_id];
    always @(posedge clk) if (bus.wr_en) rf[bus.dst_id] <= bus.dst_in;

    int   checks    = 0;
    int   failures  = 0;
    int   done_cnt  = 0;
    int   n_retired = 0;
    logic prev_we   = 1'b0;
    wr_t  sb [$];
    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Write monitor: every wr_en cycle must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (bus.done === 1'b1) done_cnt++;
        if (bus.wr_en !== 1'b0) begin
            check("wr_en_single_cycle", {31'b0, prev_we}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_write", {31'b0, bus.wr_en}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("wr_dst_id", {28'b0, bus.dst_id}, {28'b0, e.dst});
                check("wr_dst_in", {24'b0, bus.dst_in}, {24'b0, e.data});
            end
        end
        prev_we = (bus.wr_en === 1'b1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Issues one instruction from a negedge in IDLE and checks its 3-cycle retirement.
    task automatic run(input vec_t v, input string tag);
        wr_t e;
        check({tag, "_ready_idle"}, {31'b0, bus.instr_ready}, 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr_op    = v.op;
        bus.instr_dst   = v.dst;
        bus.instr_src1  = v.s1;
        bus.instr_src2  = v.s2;
        bus.instr_imm   = v.imm;
        if (v.op != OP_NOP) begin
            e.dst = v.dst;
            e.data = v.res;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check({tag, "_ready_read"}, {31'b0, bus.instr_ready}, 32'd0);
        check({tag, "_done_read"}, {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        check({tag, "_ready_wb"}, {31'b0, bus.instr_ready}, 32'd0);
        check({tag, "_done_wb"}, {31'b0, bus.done}, 32'd1);
        check({tag, "_wr_en_wb"}, {31'b0, bus.wr_en}, {31'b0, v.op != OP_NOP});
        @(negedge clk);
        n_retired++;
        check({tag, "_done_after"}, {31'b0, bus.done}, 32'd0);
        check({tag, "_flag_z"}, {31'b0, bus.flag_z}, {31'b0, v.z});
        check({tag, "_flag_c"}, {31'b0, bus.flag_c}, {31'b0, v.c});
    endtask

    initial begin
        int   accepts;
        vec_t v;

        vecs[0]  = '{OP_LDI, 4'd1,  4'd0,  4'd0,  8'd10,  8'd10,  1'b0, 1'b0};
        vecs[1]  = '{OP_LDI, 4'd2,  4'd0,  4'd0,  8'd3,   8'd3,   1'b0, 1'b0};
        vecs[2]  = '{OP_ADD, 4'd3,  4'd1,  4'd2,  8'd0,   8'd13,  1'b0, 1'b0};
        vecs[3]  = '{OP_LDI, 4'd3,  4'd0,  4'd0,  8'd200, 8'd200, 1'b0, 1'b0};
        vecs[4]  = '{OP_ADD, 4'd4,  4'd3,  4'd3,  8'd0,   8'd144, 1'b0, 1'b1};
        vecs[5]  = '{OP_SUB, 4'd5,  4'd2,  4'd1,  8'd0,   8'd249, 1'b0, 1'b1};
        vecs[6]  = '{OP_SUB, 4'd6,  4'd1,  4'd1,  8'd0,   8'd0,   1'b1, 1'b0};
        vecs[7]  = '{OP_NOP, 4'd9,  4'd1,  4'd2,  8'd55,  8'd0,   1'b1, 1'b0};
        vecs[8]  = '{OP_AND, 4'd8,  4'd1,  4'd2,  8'd0,   8'd2,   1'b0, 1'b0};
        vecs[9]  = '{OP_OR,  4'd9,  4'd1,  4'd2,  8'd0,   8'd11,  1'b0, 1'b0};
        vecs[10] = '{OP_XOR, 4'd10, 4'd1,  4'd1,  8'd0,   8'd0,   1'b1, 1'b0};
        vecs[11] = '{OP_LDI, 4'd11, 4'd0,  4'd0,  8'd255, 8'd255, 1'b0, 1'b0};
        vecs[12] = '{OP_ADD, 4'd12, 4'd11, 4'd11, 8'd0,   8'd254, 1'b0, 1'b1};
        vecs[13] = '{OP_LDI, 4'd14, 4'd0,  4'd0,  8'd1,   8'd1,   1'b0, 1'b0};
        vecs[14] = '{OP_ADD, 4'd13, 4'd11, 4'd14, 8'd0,   8'd0,   1'b1, 1'b1};
        vecs[15] = '{OP_ADD, 4'd1,  4'd1,  4'd1,  8'd0,   8'd20,  1'b0, 1'b0};
        vecs[16] = '{OP_MOV, 4'd7,  4'd1,  4'd0,  8'd0,   8'd20,  1'b0, 1'b0};

        bus.instr_valid = 1'b0;
        bus.instr_op    = '0;
        bus.instr_dst   = '0;
        bus.instr_src1  = '0;
        bus.instr_src2  = '0;
        bus.instr_imm   = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_wr_en",   {31'b0, bus.wr_en},   32'd0);
        check("rst_done",    {31'b0, bus.done},    32'd0);
        check("rst_flag_z",  {31'b0, bus.flag_z},  32'd0);
        check("rst_flag_c",  {31'b0, bus.flag_c},  32'd0);
        check("rst_dst_id",  {28'b0, bus.dst_id},  32'd0);
        check("rst_dst_in",  {24'b0, bus.dst_in},  32'd0);
        check("rst_src1_id", {28'b0, bus.src1_id}, 32'd0);
        check("rst_src2_id", {28'b0, bus.src2_id}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'b0, bus.instr_ready}, 32'd1);

        // Table of instructions, issued back-to-back at full throughput.
        for (int i = 0; i < 17; i++) run(vecs[i], $sformatf("v%0d", i));
        check("rf_r3_200", {24'b0, rf[3]}, 32'd200);
        check("rf_r1_raw", {24'b0, rf[1]}, 32'd20);
        check("rf_r7_mov", {24'b0, rf[7]}, 32'd20);

        // instr_valid held for 6 cycles: exactly two accepts.
        accepts = 0;
        bus.instr_op   = OP_LDI;
        bus.instr_dst  = 4'd15;
        bus.instr_imm  = 8'd77;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.instr_ready) begin
                accepts++;
                sb.push_back('{4'd15, 8'd77});
            end
            check($sformatf("held_ready_c%0d", i), {31'b0, bus.instr_ready}, {31'b0, (i % 3) == 0});
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        n_retired += 2;
        @(negedge clk);
        check("held_accepts", accepts, 32'd2);
        check("held_rf15", {24'b0, rf[15]}, 32'd77);

        // Set carry first so the reset clear is visible: 3 - 20 = 239 with borrow.
        v = '{OP_SUB, 4'd5, 4'd2, 4'd1, 8'd0, 8'd239, 1'b0, 1'b1};
        run(v, "pre_rst_sub");

        // Reset during READ of ADD r3,r1,r2: aborted, no write, flags cleared.
        bus.instr_op    = OP_ADD;
        bus.instr_dst   = 4'd3;
        bus.instr_src1  = 4'd1;
        bus.instr_src2  = 4'd2;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check("abort_in_read", {31'b0, bus.instr_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("abort_flag_z", {31'b0, bus.flag_z}, 32'd0);
        check("abort_flag_c", {31'b0, bus.flag_c}, 32'd0);
        @(negedge clk);
        check("abort_wr_en", {31'b0, bus.wr_en}, 32'd0);
        check("abort_done",  {31'b0, bus.done},  32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_next", {31'b0, bus.instr_ready}, 32'd1);
        @(negedge clk);
        check("abort_rf_r3", {24'b0, rf[3]}, 32'd200);
        check("abort_flags", {30'b0, bus.flag_z, bus.flag_c}, 32'd0);

        check("sb_drained", sb.size(), 32'd0);
        check("done_pulses", done_cnt, n_retired);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
